// File: rtl/seg_scroll_n.sv
// seg_scroll_n -- N-digit scrolling 7-segment display engine.
//
// On every scroll tick the engine takes one digit from the receive FIFO
// through a read handshake. If the FIFO is empty it inserts a fill digit
// instead. It then shifts the digit row in the direction selected by i_dir
// and drives registered active-low segment patterns for every digit.
// o_start flags the first FIFO digit that follows a fill step, so the
// UART TX echo path can begin a new message.
//
// Optional feature macro: SCROLL_RECIRC_EN
//   defined   : the fill digit is the digit shifted out of the row, so an
//               empty FIFO rotates the display.
//   undefined : the fill digit is BLANK_CODE.
//
// Parameters
//   NUM_DIGITS  number of display digits (>= 2)
//   DIG_W       width of one digit code (>= 4)
//   BLANK_CODE  code that displays all segments off
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   i_tick        one-clk scroll strobe
//   i_clean       synchronous clear of the display and engine (highest priority)
//   i_dir         0: shift toward higher index, 1: shift toward lower index
//   i_fifo_empty  FIFO empty flag, sampled when a step starts
//   i_fifo_data   FIFO read data, valid the cycle after o_fifo_rd
//   o_fifo_rd     FIFO read strobe, one cycle per consumed digit
//   o_digits      digit row, digit k at [k*DIG_W +: DIG_W]
//   o_seg         segments {g,f,e,d,c,b,a} for digit k at [k*7 +: 7], active-low
//   o_busy        high while a scroll step is in progress
//   o_start       one-clk pulse at the start of a message
module seg_scroll_n #(
  parameter int               NUM_DIGITS = 3,
  parameter int               DIG_W      = 4,
  parameter logic [DIG_W-1:0] BLANK_CODE = 4'hF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_tick,
  input  logic                        i_clean,
  input  logic                        i_dir,
  input  logic                        i_fifo_empty,
  input  logic [DIG_W-1:0]            i_fifo_data,
  output logic                        o_fifo_rd,
  output logic [NUM_DIGITS*DIG_W-1:0] o_digits,
  output logic [NUM_DIGITS*7-1:0]     o_seg,
  output logic                        o_busy,
  output logic                        o_start
);

  localparam int ROW_W = NUM_DIGITS * DIG_W;
  localparam int SEG_W = NUM_DIGITS * 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LAT  = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             stepGo;
  logic             srcFifo;
  logic             pending;
  logic             prevFill;
  logic             startP1;
  logic [DIG_W-1:0] fillDigit;
  logic [DIG_W-1:0] newDigit;
  logic [ROW_W-1:0] digitsP1;
  logic [ROW_W-1:0] digitsNext;
  logic [SEG_W-1:0] segNext;
  logic [SEG_W-1:0] segP2;

  // Active-low segment decode, bit order {g,f,e,d,c,b,a}. The blank code
  // is tested first so it wins even if it is chosen inside 0..9.
  function automatic logic [6:0] decodeSeg(input logic [DIG_W-1:0] code);
    logic [6:0] seg;
    if (code == BLANK_CODE) begin
      seg = 7'b1111111;
    end else begin
      case (code)
        DIG_W'(0): seg = 7'b1000000;
        DIG_W'(1): seg = 7'b1111001;
        DIG_W'(2): seg = 7'b0100100;
        DIG_W'(3): seg = 7'b0110000;
        DIG_W'(4): seg = 7'b0011001;
        DIG_W'(5): seg = 7'b0010010;
        DIG_W'(6): seg = 7'b0000010;
        DIG_W'(7): seg = 7'b1111000;
        DIG_W'(8): seg = 7'b0000000;
        DIG_W'(9): seg = 7'b0010000;
        default:   seg = 7'b0111111;
      endcase
    end
    return seg;
  endfunction

  // A queued tick starts a step exactly like a fresh one.
  assign stepGo = (state == IDLE) && (i_tick || pending);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (stepGo) stateNext = RD;
      RD:      stateNext = LAT;
      LAT:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (i_clean) stateNext = IDLE;
  end

  // ---- Stage p0: step control (source select, tick queue, message start)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcFifo  <= 1'b0;
      pending  <= 1'b0;
      prevFill <= 1'b1;
      startP1  <= 1'b0;
    end else if (i_clean) begin
      srcFifo  <= 1'b0;
      pending  <= 1'b0;
      prevFill <= 1'b1;
      startP1  <= 1'b0;
    end else begin
      startP1 <= 1'b0;
      case (state)
        IDLE: begin
          // Empty flag is only looked at here; later changes in the same
          // step are ignored.
          if (stepGo) begin
            srcFifo <= !i_fifo_empty;
            pending <= 1'b0;
          end
        end
        RD: begin
          // One-deep queue: a tick while pending is already set is lost.
          if (i_tick) pending <= 1'b1;
        end
        LAT: begin
          if (i_tick) pending <= 1'b1;
          startP1  <= srcFifo && prevFill;
          prevFill <= !srcFifo;
        end
        default: ;
      endcase
    end
  end

  // ---- Stage p1: new digit and row shift
`ifdef SCROLL_RECIRC_EN
  // Reuse the digit that this shift would otherwise discard.
  assign fillDigit = i_dir ? digitsP1[DIG_W-1:0] : digitsP1[ROW_W-1 -: DIG_W];
`else
  assign fillDigit = BLANK_CODE;
`endif

  assign newDigit   = srcFifo ? i_fifo_data : fillDigit;
  assign digitsNext = i_dir ? {newDigit, digitsP1[ROW_W-1:DIG_W]}
                            : {digitsP1[ROW_W-DIG_W-1:0], newDigit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digitsP1 <= {NUM_DIGITS{BLANK_CODE}};
    end else if (i_clean) begin
      digitsP1 <= {NUM_DIGITS{BLANK_CODE}};
    end else if (state == LAT) begin
      digitsP1 <= digitsNext;
    end
  end

  // ---- Stage p2: registered segment decode of the whole row
  always_comb begin
    segNext = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      segNext[k*7 +: 7] = decodeSeg(digitsP1[k*DIG_W +: DIG_W]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      segP2 <= '1;
    end else begin
      segP2 <= segNext;
    end
  end

  assign o_fifo_rd = (state == RD) && srcFifo;
  assign o_busy    = (state != IDLE);
  assign o_start   = startP1;
  assign o_digits  = digitsP1;
  assign o_seg     = segP2;

endmodule

// File: tb/tb_seg_scroll_n.sv
`timescale 1ns/1ps
module tb_seg_scroll_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        clean;
  logic        dir;
  logic        fifoEmpty;
  logic [3:0]  fifoData = 4'h0;
  logic        fifoRd;
  logic [11:0] digits;
  logic [20:0] seg;
  logic        busy;
  logic        start;

  logic [3:0]  fifoMem [0:31];
  int          wrPtr = 0;
  int          rdPtr = 0;
  int          startCount = 0;
  int          passCount = 0;
  int          totalCount = 0;

`ifdef SCROLL_RECIRC_EN
  localparam logic [11:0] FILL_ROW = 12'h231;
  localparam logic [20:0] FILL_SEG = {7'b0100100, 7'b0110000, 7'b1111001};
`else
  localparam logic [11:0] FILL_ROW = 12'h23F;
  localparam logic [20:0] FILL_SEG = {7'b0100100, 7'b0110000, 7'b1111111};
`endif

  seg_scroll_n #(
    .NUM_DIGITS(3),
    .DIG_W(4),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .i_tick(tick),
    .i_clean(clean),
    .i_dir(dir),
    .i_fifo_empty(fifoEmpty),
    .i_fifo_data(fifoData),
    .o_fifo_rd(fifoRd),
    .o_digits(digits),
    .o_seg(seg),
    .o_busy(busy),
    .o_start(start)
  );

  always #5 clk = ~clk;

  // FIFO model with registered read data, plus an o_start pulse counter.
  assign fifoEmpty = (wrPtr == rdPtr);
  always @(posedge clk) begin
    if (fifoRd) begin
      fifoData <= fifoMem[rdPtr[4:0]];
      rdPtr    <= rdPtr + 1;
    end
    if (start) startCount <= startCount + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    fifoMem[wrPtr[4:0]] = v;
    wrPtr = wrPtr + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; clean = 1'b0; dir = 1'b0;
    repeat (2) cyc();
    totalCount++;
    if (digits !== 12'hFFF) $display("FAIL reset_digits: got %h want %h", digits, 12'hFFF);
    else passCount++;
    totalCount++;
    if (seg !== 21'h1FFFFF) $display("FAIL reset_seg: got %h want %h", seg, 21'h1FFFFF);
    else passCount++;
    totalCount++;
    if (fifoRd !== 1'b0) $display("FAIL reset_rd: got %b want 0", fifoRd);
    else passCount++;
    totalCount++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passCount++;
    totalCount++;
    if (start !== 1'b0) $display("FAIL reset_start: got %b want 0", start);
    else passCount++;
    rst_n = 1'b1;
    repeat (2) cyc();
    totalCount++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
    else passCount++;
  endtask

  task automatic test_fifo_seq();
    int rd0, st0;
    push(4'd1); push(4'd2); push(4'd3);
    dir = 1'b0; rd0 = rdPtr; st0 = startCount;
    tick = 1'b1; cyc(); tick = 1'b0;
    totalCount++;
    if (fifoRd !== 1'b1) $display("FAIL seq_rd_e0: got %b want 1", fifoRd);
    else passCount++;
    totalCount++;
    if (busy !== 1'b1) $display("FAIL seq_busy_e0: got %b want 1", busy);
    else passCount++;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'hFF1) $display("FAIL seq_step1_digits: got %h want %h", digits, 12'hFF1);
    else passCount++;
    totalCount++;
    if (start !== 1'b1) $display("FAIL seq_step1_start: got %b want 1", start);
    else passCount++;
    tick = 1'b1; cyc(); tick = 1'b0;
    totalCount++;
    if (start !== 1'b0) $display("FAIL seq_start_width: got %b want 0", start);
    else passCount++;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'hF12) $display("FAIL seq_step2_digits: got %h want %h", digits, 12'hF12);
    else passCount++;
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'h123) $display("FAIL seq_step3_digits: got %h want %h", digits, 12'h123);
    else passCount++;
    cyc();
    totalCount++;
    if (seg !== {7'b1111001, 7'b0100100, 7'b0110000})
      $display("FAIL seq_seg: got %h want %h", seg, {7'b1111001, 7'b0100100, 7'b0110000});
    else passCount++;
    totalCount++;
    if (rdPtr - rd0 !== 3) $display("FAIL seq_reads: got %0d want 3", rdPtr - rd0);
    else passCount++;
    totalCount++;
    if (startCount - st0 !== 1) $display("FAIL seq_starts: got %0d want 1", startCount - st0);
    else passCount++;
  endtask

  task automatic test_fill();
    dir = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    totalCount++;
    if (fifoRd !== 1'b0) $display("FAIL fill_rd: got %b want 0", fifoRd);
    else passCount++;
    cyc(); cyc();
    totalCount++;
    if (digits !== FILL_ROW) $display("FAIL fill_digits: got %h want %h", digits, FILL_ROW);
    else passCount++;
    totalCount++;
    if (start !== 1'b0) $display("FAIL fill_start: got %b want 0", start);
    else passCount++;
    cyc();
    totalCount++;
    if (seg !== FILL_SEG) $display("FAIL fill_seg: got %h want %h", seg, FILL_SEG);
    else passCount++;
  endtask

  task automatic test_dir_down();
    push(4'd7);
    dir = 1'b1;
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'h723) $display("FAIL dir1_digits: got %h want %h", digits, 12'h723);
    else passCount++;
    totalCount++;
    if (start !== 1'b1) $display("FAIL dir1_start: got %b want 1", start);
    else passCount++;
    cyc();
    totalCount++;
    if (seg !== {7'b1111000, 7'b0100100, 7'b0110000})
      $display("FAIL dir1_seg: got %h want %h", seg, {7'b1111000, 7'b0100100, 7'b0110000});
    else passCount++;
    dir = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rd0;
    push(4'd4); push(4'd5); push(4'd6);
    rd0 = rdPtr;
    tick = 1'b1;
    cyc(); cyc(); cyc();
    tick = 1'b0;
    totalCount++;
    if (digits !== 12'h234) $display("FAIL b2b_step1_digits: got %h want %h", digits, 12'h234);
    else passCount++;
    cyc();
    totalCount++;
    if (busy !== 1'b1) $display("FAIL b2b_pending_busy: got %b want 1", busy);
    else passCount++;
    totalCount++;
    if (fifoRd !== 1'b1) $display("FAIL b2b_pending_rd: got %b want 1", fifoRd);
    else passCount++;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'h345) $display("FAIL b2b_step2_digits: got %h want %h", digits, 12'h345);
    else passCount++;
    repeat (3) cyc();
    totalCount++;
    if (busy !== 1'b0) $display("FAIL b2b_third_dropped_busy: got %b want 0", busy);
    else passCount++;
    totalCount++;
    if (digits !== 12'h345) $display("FAIL b2b_final_digits: got %h want %h", digits, 12'h345);
    else passCount++;
    totalCount++;
    if (rdPtr - rd0 !== 2) $display("FAIL b2b_reads: got %0d want 2", rdPtr - rd0);
    else passCount++;
  endtask

  task automatic test_clean_in_rd();
    int rd0;
    rd0 = rdPtr;
    tick = 1'b1; cyc(); tick = 1'b0;
    totalCount++;
    if (fifoRd !== 1'b1) $display("FAIL clean_rd_strobe: got %b want 1", fifoRd);
    else passCount++;
    clean = 1'b1; cyc(); clean = 1'b0;
    totalCount++;
    if (busy !== 1'b0) $display("FAIL clean_busy: got %b want 0", busy);
    else passCount++;
    totalCount++;
    if (digits !== 12'hFFF) $display("FAIL clean_digits: got %h want %h", digits, 12'hFFF);
    else passCount++;
    repeat (3) cyc();
    totalCount++;
    if (digits !== 12'hFFF) $display("FAIL clean_word_hidden: got %h want %h", digits, 12'hFFF);
    else passCount++;
    totalCount++;
    if (seg !== 21'h1FFFFF) $display("FAIL clean_seg: got %h want %h", seg, 21'h1FFFFF);
    else passCount++;
    totalCount++;
    if (rdPtr - rd0 !== 1) $display("FAIL clean_reads: got %0d want 1", rdPtr - rd0);
    else passCount++;
  endtask

  task automatic test_reset_mid_step();
    push(4'd8);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'hFF8) $display("FAIL after_clean_digits: got %h want %h", digits, 12'hFF8);
    else passCount++;
    totalCount++;
    if (start !== 1'b1) $display("FAIL after_clean_start: got %b want 1", start);
    else passCount++;
    push(4'd9);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    totalCount++;
    if (digits !== 12'hFFF) $display("FAIL mid_reset_digits: got %h want %h", digits, 12'hFFF);
    else passCount++;
    totalCount++;
    if (seg !== 21'h1FFFFF) $display("FAIL mid_reset_seg: got %h want %h", seg, 21'h1FFFFF);
    else passCount++;
    totalCount++;
    if (fifoRd !== 1'b0) $display("FAIL mid_reset_rd: got %b want 0", fifoRd);
    else passCount++;
    totalCount++;
    if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy);
    else passCount++;
    totalCount++;
    if (start !== 1'b0) $display("FAIL mid_reset_start: got %b want 0", start);
    else passCount++;
    cyc();
    rst_n = 1'b1;
    cyc();
    totalCount++;
    if (digits !== 12'hFFF) $display("FAIL post_reset_digits: got %h want %h", digits, 12'hFFF);
    else passCount++;
    push(4'd5);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'hFF5) $display("FAIL post_reset_step_digits: got %h want %h", digits, 12'hFF5);
    else passCount++;
    totalCount++;
    if (start !== 1'b1) $display("FAIL post_reset_start: got %b want 1", start);
    else passCount++;
  endtask

  task automatic test_dash();
    push(4'hA);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    totalCount++;
    if (digits !== 12'hF5A) $display("FAIL dash_digits: got %h want %h", digits, 12'hF5A);
    else passCount++;
    totalCount++;
    if (start !== 1'b0) $display("FAIL dash_start: got %b want 0", start);
    else passCount++;
    cyc();
    totalCount++;
    if (seg !== {7'b1111111, 7'b0010010, 7'b0111111})
      $display("FAIL dash_seg: got %h want %h", seg, {7'b1111111, 7'b0010010, 7'b0111111});
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_fifo_seq();
    test_fill();
    test_dir_down();
    test_back_to_back();
    test_clean_in_rd();
    test_reset_mid_step();
    test_dash();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
